reg_wb_ctrl: RTL and testbench
==============================

// Module: reg_wb_ctrl
// PURPOSE
//  Write-side controller for REG_FILE. Merges results from two pipeline sources (ALU, MEM) into
//  REG_FILE's single write port (w_addr/w_data/reg_we) and dedicated R14 port (w_reg14/reg14_we).
//  Holds results in a small in-order queue until written. Supplies bypass data for pending writes
//  so the operand-fetch stage never reads a stale register.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >=2
//  DW      16  data width
//  AW      4   register address width (16 registers)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   synchronous reset, active-high
//  alu_valid     in   1   ALU result offered
//  alu_we        in   1   ALU result writes general register alu_addr
//  alu_addr      in   AW  ALU destination register
//  alu_data      in   DW  ALU general-register data
//  alu_r14_we    in   1   ALU result also writes R14 through dedicated port
//  alu_r14_data  in   DW  ALU R14 data
//  mem_valid/mem_we/mem_addr/mem_data/mem_r14_we/mem_r14_data   in   same widths, MEM source
//  in_ready      out  1   both sources may present this cycle
//  reg_we        out  1   to REG_FILE
//  w_addr        out  AW  to REG_FILE
//  w_data        out  DW  to REG_FILE
//  reg14_we      out  1   to REG_FILE
//  w_reg14       out  DW  to REG_FILE
//  op1_addr      in   AW  operand-fetch read address 1
//  op2_addr      in   AW  operand-fetch read address 2
//  byp1_hit      out  1   pending write to op1_addr exists
//  byp1_data     out  DW  youngest pending value for op1_addr
//  byp2_hit/byp2_data   out  1/DW   same, for op2_addr
//  occ           out  log2(DEPTH)+1   entries queued
//  err           out  1   sticky: illegal R14 double write seen
// BEHAVIOUR
//  - Reset: queue empty, occ=0, reg_we=reg14_we=0, w_addr=0, w_data=0, w_reg14=0, err=0,
//    byp*_hit=0. in_ready=1 in the first cycle after reset.
//  - in_ready = (DEPTH-occ >= 2). Registered from occ; does not depend on valids.
//  - Accept: source with valid&in_ready and (we|r14_we) enqueued at edge. Valid with both we=0 is
//    dropped (no entry). Valid while in_ready=0 is ignored; the source holds it.
//  - Ordering: same-cycle MEM entry is older than the ALU entry and enqueues first.
//  - Drain: head drives outputs combinationally (reg_we=head.we, reg14_we=head.r14_we, etc.).
//    Head is committed and popped every cycle it is valid, so there is no backpressure from REG_FILE.
//    Empty queue: both we=0 and data/addr=0.
//  - Latency: entry accepted at edge N drives the port in cycle N+1 if the queue was empty.
//    REG_FILE commits it at edge N+1.
//  - Simultaneous push(2)+pop(1): occ += 1. Pointers wrap modulo DEPTH.
//  - R14 conflict: entry with we=1, addr=14 and r14_we=1 -> general write dropped at enqueue.
//    The R14 port write is kept and err is set (sticky until rst).
//  - Bypass: hit if any queued entry writes that register. For address 14 this means we&addr==14
//    or r14_we. Data is from the youngest matching entry; the head is included.
//    Same-cycle incoming results are not bypassed.
//  - R0 is an ordinary register; no special-casing.
//  - rst mid-operation: queued entries discarded, not written. Write port deasserts the cycle
//    after the reset edge.
// STRUCTURE
//  - reg_wb_defs.vh: AW, DW, R14_ADDR=4'hE, entry field widths/offsets (we, r14_we, addr, data,
//    r14_data).
//  - One sub-module: wb_queue (2-push, 1-pop in-order circular buffer).
//    Exposes all entries plus valid bits for bypass search.
//  - Top holds accept/drop/conflict logic, port drive and priority bypass mux.
// TESTING
//  1 Reset then ALU {we,addr=1,data=3142} -> cycle N+1: reg_we=1, w_addr=1, w_data=3142; occ back to 0.
//  2 Same cycle MEM {addr=8,data=BEEF} and ALU {addr=8,data=DEAD}
//    -> writes BEEF then DEAD on consecutive cycles; byp hit for 8 returns DEAD while both queued.
//  3 ALU {r14_we, r14_data=5678, we=0} -> reg14_we=1, w_reg14=5678, reg_we=0;
//    op2_addr=E hit=1 data=5678 until drained.
//  4 Both sources valid 3 consecutive cycles with DEPTH=4 -> in_ready drops at occ>=3;
//    no entry lost or reordered; all 6 writes appear in order.
//  5 ALU {we,addr=E,r14_we,data=1111,r14_data=2222} -> only reg14_we with 2222; err=1 stays set.
//  6 Queue holding 3 entries, assert rst one cycle -> no further writes; occ=0; outputs zero; err=0.

Source files
------------

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared widths, queue entry layout and entry helpers for the register write-back controller.
package reg_wb_ctrl_pkg;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [AW-1:0] R14_ADDR = 4'hE;

  typedef struct packed {
    logic          we;
    logic          r14_we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] r14_data;
  } wb_entry_t;

  // A general write to R14 together with a dedicated-port R14 write cannot both land.
  function automatic logic is_r14_conflict(input logic we, input logic r14_we,
                                           input logic [AW-1:0] addr);
    return we & r14_we & (addr == R14_ADDR);
  endfunction

  function automatic wb_entry_t make_entry(input logic we, input logic r14_we,
                                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                           input logic [DW-1:0] r14_data);
    wb_entry_t e;
    e.we       = we & ~is_r14_conflict(we, r14_we, addr);
    e.r14_we   = r14_we;
    e.addr     = addr;
    e.data     = data;
    e.r14_data = r14_data;
    return e;
  endfunction

  function automatic logic entry_hits(input wb_entry_t e, input logic [AW-1:0] a);
    return (e.we & (e.addr == a)) | (e.r14_we & (a == R14_ADDR));
  endfunction

  function automatic logic [DW-1:0] entry_value(input wb_entry_t e, input logic [AW-1:0] a);
    if (e.r14_we && (a == R14_ADDR)) begin
      return e.r14_data;
    end else begin
      return e.data;
    end
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bundle of source, register-file write and bypass signals around the write-back controller.
interface reg_wb_ctrl_if;
  import reg_wb_ctrl_pkg::*;

  logic          alu_valid;
  logic          alu_we;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_r14_we;
  logic [DW-1:0] alu_r14_data;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_r14_we;
  logic [DW-1:0] mem_r14_data;
  logic          in_ready;

  logic          reg_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          reg14_we;
  logic [DW-1:0] w_reg14;

  logic [AW-1:0] op1_addr;
  logic [AW-1:0] op2_addr;
  logic          byp1_hit;
  logic [DW-1:0] byp1_data;
  logic          byp2_hit;
  logic [DW-1:0] byp2_data;

  logic [OCC_W-1:0] occ;
  logic             err;

  modport master (
    output alu_valid, alu_we, alu_addr, alu_data, alu_r14_we, alu_r14_data,
    output mem_valid, mem_we, mem_addr, mem_data, mem_r14_we, mem_r14_data,
    output op1_addr, op2_addr,
    input  in_ready, reg_we, w_addr, w_data, reg14_we, w_reg14,
    input  byp1_hit, byp1_data, byp2_hit, byp2_data, occ, err
  );

  modport slave (
    input  alu_valid, alu_we, alu_addr, alu_data, alu_r14_we, alu_r14_data,
    input  mem_valid, mem_we, mem_addr, mem_data, mem_r14_we, mem_r14_data,
    input  op1_addr, op2_addr,
    output in_ready, reg_we, w_addr, w_data, reg14_we, w_reg14,
    output byp1_hit, byp1_data, byp2_hit, byp2_data, occ, err
  );

endinterface

// File: rtl/reg_wb_ctrl_queue.sv
// In-order circular buffer with two pushes (older first) and one pop per cycle.
// Entries are presented in age order, oldest at index 0, for head drive and bypass search.
module wb_queue
  import reg_wb_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_old_valid,
  input  wb_entry_t        push_old,
  input  logic             push_new_valid,
  input  wb_entry_t        push_new,
  input  logic             pop,
  output wb_entry_t        ent_by_age [DEPTH],
  output logic [DEPTH-1:0] vld_by_age,
  output logic [OCC_W-1:0] occ,
  output logic [OCC_W-1:0] occ_next
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_s;
  logic             pop_s;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_s = tail_q;
    pop_s    = pop & (occ_q != {OCC_W{1'b0}});
    if (push_old_valid) begin
      mem_d[wr_ptr_s] = push_old;
      wr_ptr_s        = wr_ptr_s + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_s = wr_ptr_s;
    end
    if (push_new_valid) begin
      mem_d[wr_ptr_s] = push_new;
      wr_ptr_s        = wr_ptr_s + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_s = wr_ptr_s;
    end
    tail_d = wr_ptr_s;
    head_d = pop_s ? head_q + {{(PTR_W-1){1'b0}}, 1'b1} : head_q;
    occ_d  = occ_q + OCC_W'(push_old_valid) + OCC_W'(push_new_valid) - OCC_W'(pop_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= {PTR_W{1'b0}};
      tail_q <= {PTR_W{1'b0}};
      occ_q  <= {OCC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      mem_q  <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_by_age[i] = mem_q[head_q + PTR_W'(i)];
      vld_by_age[i] = (OCC_W'(i) < occ_q);
    end
  end

  assign occ      = occ_q;
  assign occ_next = occ_d;

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-side controller for the register file: queues ALU/MEM results in order, drains one
// per cycle into the general and R14 write ports, and serves bypass data for pending writes.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  reg_wb_ctrl_if.slave bus
);

  logic             in_ready_q, in_ready_d;
  logic             err_q, err_d;
  logic             mem_take_s, alu_take_s;
  wb_entry_t        mem_ent_s, alu_ent_s;
  wb_entry_t        ent_s [DEPTH];
  logic [DEPTH-1:0] vld_s;
  logic [OCC_W-1:0] occ_s, occ_next_s;

  // Dropped results (no write enable at all) never take a slot.
  always_comb begin
    mem_take_s = bus.mem_valid & in_ready_q & (bus.mem_we | bus.mem_r14_we);
    alu_take_s = bus.alu_valid & in_ready_q & (bus.alu_we | bus.alu_r14_we);
    mem_ent_s  = make_entry(bus.mem_we, bus.mem_r14_we, bus.mem_addr, bus.mem_data,
                            bus.mem_r14_data);
    alu_ent_s  = make_entry(bus.alu_we, bus.alu_r14_we, bus.alu_addr, bus.alu_data,
                            bus.alu_r14_data);
    err_d      = err_q
               | (mem_take_s & is_r14_conflict(bus.mem_we, bus.mem_r14_we, bus.mem_addr))
               | (alu_take_s & is_r14_conflict(bus.alu_we, bus.alu_r14_we, bus.alu_addr));
    in_ready_d = (occ_next_s <= OCC_W'(DEPTH - 2));
  end

  wb_queue u_queue (
    .clk            (clk),
    .rst            (rst),
    .push_old_valid (mem_take_s),
    .push_old       (mem_ent_s),
    .push_new_valid (alu_take_s),
    .push_new       (alu_ent_s),
    .pop            (vld_s[0]),
    .ent_by_age     (ent_s),
    .vld_by_age     (vld_s),
    .occ            (occ_s),
    .occ_next       (occ_next_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  // The register file always commits the head, so the port follows the head directly.
  always_comb begin
    if (vld_s[0]) begin
      bus.reg_we   = ent_s[0].we;
      bus.w_addr   = ent_s[0].addr;
      bus.w_data   = ent_s[0].data;
      bus.reg14_we = ent_s[0].r14_we;
      bus.w_reg14  = ent_s[0].r14_data;
    end else begin
      bus.reg_we   = 1'b0;
      bus.w_addr   = {AW{1'b0}};
      bus.w_data   = {DW{1'b0}};
      bus.reg14_we = 1'b0;
      bus.w_reg14  = {DW{1'b0}};
    end
  end

  // Later (younger) matches overwrite earlier ones, giving youngest-wins priority.
  always_comb begin
    bus.byp1_hit  = 1'b0;
    bus.byp1_data = {DW{1'b0}};
    bus.byp2_hit  = 1'b0;
    bus.byp2_data = {DW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_s[i] && entry_hits(ent_s[i], bus.op1_addr)) begin
        bus.byp1_hit  = 1'b1;
        bus.byp1_data = entry_value(ent_s[i], bus.op1_addr);
      end else begin
        bus.byp1_hit  = bus.byp1_hit;
      end
      if (vld_s[i] && entry_hits(ent_s[i], bus.op2_addr)) begin
        bus.byp2_hit  = 1'b1;
        bus.byp2_data = entry_value(ent_s[i], bus.op2_addr);
      end else begin
        bus.byp2_hit  = bus.byp2_hit;
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.occ      = occ_s;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed scenarios plus randomized traffic checked against a queue-of-pending-writes model.
module tb_reg_wb_ctrl;

  typedef struct {
    logic        we;
    logic        r14;
    logic [3:0]  addr;
    logic [15:0] d;
    logic [15:0] r;
  } mdl_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  reg_wb_ctrl_if bus ();

  reg_wb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mdl_t        mq[$];
  logic        err_m;
  logic        a_v, a_we, a_r14, m_v, m_we, m_r14;
  logic [3:0]  a_addr, m_addr, op1, op2;
  logic [15:0] a_d, a_r, m_d, m_r;
  logic        a_taken, m_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [3:0] a, output logic hit, output logic [15:0] val);
    hit = 1'b0;
    val = 16'h0000;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].we && mq[i].addr == a) begin
        hit = 1'b1; val = mq[i].d; break;
      end
      if (mq[i].r14 && a == 4'hE) begin
        hit = 1'b1; val = mq[i].r; break;
      end
    end
  endtask

  task automatic enq(input logic we, input logic r14, input logic [3:0] ad,
                     input logic [15:0] d, input logic [15:0] r);
    mdl_t e;
    if (!(we || r14)) return;
    e.we = we; e.r14 = r14; e.addr = ad; e.d = d; e.r = r;
    if (we && r14 && ad == 4'hE) begin
      e.we  = 1'b0;
      err_m = 1'b1;
    end
    mq.push_back(e);
  endtask

  task automatic step();
    logic        rdy, bh;
    logic [15:0] bd;
    bus.alu_valid = a_v; bus.alu_we = a_we; bus.alu_addr = a_addr; bus.alu_data = a_d;
    bus.alu_r14_we = a_r14; bus.alu_r14_data = a_r;
    bus.mem_valid = m_v; bus.mem_we = m_we; bus.mem_addr = m_addr; bus.mem_data = m_d;
    bus.mem_r14_we = m_r14; bus.mem_r14_data = m_r;
    bus.op1_addr = op1; bus.op2_addr = op2;
    #1;
    rdy = (mq.size() <= 2);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("occ", 32'(bus.occ), 32'(mq.size()));
    chk("err", 32'(bus.err), 32'(err_m));
    if (mq.size() > 0) begin
      chk("reg_we", 32'(bus.reg_we), 32'(mq[0].we));
      chk("reg14_we", 32'(bus.reg14_we), 32'(mq[0].r14));
      if (mq[0].we) begin
        chk("w_addr", 32'(bus.w_addr), 32'(mq[0].addr));
        chk("w_data", 32'(bus.w_data), 32'(mq[0].d));
      end
      if (mq[0].r14) chk("w_reg14", 32'(bus.w_reg14), 32'(mq[0].r));
    end else begin
      chk("idle_port", {bus.reg_we, bus.reg14_we, 10'(bus.w_addr), bus.w_data}, 32'h0);
      chk("idle_r14", 32'(bus.w_reg14), 32'h0);
    end
    lookup(op1, bh, bd);
    chk("byp1_hit", 32'(bus.byp1_hit), 32'(bh));
    if (bh) chk("byp1_data", 32'(bus.byp1_data), 32'(bd));
    lookup(op2, bh, bd);
    chk("byp2_hit", 32'(bus.byp2_hit), 32'(bh));
    if (bh) chk("byp2_data", 32'(bus.byp2_data), 32'(bd));
    m_taken = m_v && rdy;
    a_taken = a_v && rdy;
    if (mq.size() > 0) void'(mq.pop_front());
    if (m_taken) enq(m_we, m_r14, m_addr, m_d, m_r);
    if (a_taken) enq(a_we, a_r14, a_addr, a_d, a_r);
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic we, input logic r14, input logic [3:0] ad,
                         input logic [15:0] d, input logic [15:0] r);
    a_v = v; a_we = we; a_r14 = r14; a_addr = ad; a_d = d; a_r = r;
  endtask

  task automatic set_mem(input logic v, input logic we, input logic r14, input logic [3:0] ad,
                         input logic [15:0] d, input logic [15:0] r);
    m_v = v; m_we = we; m_r14 = r14; m_addr = ad; m_d = d; m_r = r;
  endtask

  task automatic rand_src(output logic v, output logic we, output logic r14,
                          output logic [3:0] ad, output logic [15:0] d, output logic [15:0] r);
    v = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 7))
      0:       begin we = 1'b0; r14 = 1'b1; end
      1:       begin we = 1'b1; r14 = 1'b1; end
      2:       begin we = 1'b0; r14 = 1'b0; end
      default: begin we = 1'b1; r14 = 1'b0; end
    endcase
    ad = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 5));
    d  = 16'($urandom);
    r  = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_alu(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_mem(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    err_m = 1'b0;
  endtask

  initial begin
    int na, nm;
    vectors = 0; miscompares = 0;
    err_m = 1'b0; a_taken = 1'b0; m_taken = 1'b0;
    op1 = 4'h0; op2 = 4'h0;
    bus.op1_addr = 4'h0; bus.op2_addr = 4'h0;
    do_reset();
    step();

    // single ALU write, one-cycle latency
    set_alu(1'b1, 1'b1, 1'b0, 4'h1, 16'h3142, 16'h0);
    op1 = 4'h1;
    step();
    set_alu(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (3) step();

    // MEM older than ALU, bypass returns the younger value
    set_mem(1'b1, 1'b1, 1'b0, 4'h8, 16'hBEEF, 16'h0);
    set_alu(1'b1, 1'b1, 1'b0, 4'h8, 16'hDEAD, 16'h0);
    op1 = 4'h8; op2 = 4'h8;
    step();
    set_mem(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_alu(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (3) step();

    // R14-only write and bypass through address E
    set_alu(1'b1, 1'b0, 1'b1, 4'h3, 16'h0, 16'h5678);
    op2 = 4'hE;
    step();
    set_alu(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (3) step();

    // both sources streaming three results each; sources hold while not ready
    na = 0; nm = 0;
    set_alu(1'b1, 1'b1, 1'b0, 4'h2, 16'hA000, 16'h0);
    set_mem(1'b1, 1'b1, 1'b0, 4'h2, 16'hB000, 16'h0);
    op1 = 4'h2;
    for (int k = 0; k < 20 && (na < 3 || nm < 3); k++) begin
      step();
      if (a_taken) begin
        na++;
        set_alu(na < 3, 1'b1, 1'b0, 4'h2, 16'hA000 + 16'(na), 16'h0);
      end
      if (m_taken) begin
        nm++;
        set_mem(nm < 3, 1'b1, 1'b0, 4'(na + 4), 16'hB000 + 16'(nm), 16'h0);
      end
    end
    repeat (4) step();

    // R14 double write: general write dropped, error sticky
    set_alu(1'b1, 1'b1, 1'b1, 4'hE, 16'h1111, 16'h2222);
    op1 = 4'hE;
    step();
    set_alu(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (3) step();

    // reset with three entries queued
    set_alu(1'b1, 1'b1, 1'b0, 4'h5, 16'h0055, 16'h0);
    set_mem(1'b1, 1'b0, 1'b1, 4'h6, 16'h0066, 16'h0666);
    step();
    step();
    do_reset();
    repeat (2) step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!a_v || a_taken) rand_src(a_v, a_we, a_r14, a_addr, a_d, a_r);
      if (!m_v || m_taken) rand_src(m_v, m_we, m_r14, m_addr, m_d, m_r);
      op1 = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 5));
      op2 = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 5));
      step();
      if (n == 250) begin
        do_reset();
        step();
      end
    end
    set_alu(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_mem(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
